// File: rtl/axi_burst_ram_slave_if.sv
// AXI4 bus bundle between the wrapper and the burst RAM slave.
// Lock/cache/prot/qos/region/user are not part of the bundle.
interface axi_burst_ram_slave_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10
);
  logic [ID_W-1:0]     s00_axi_awid;
  logic [ADDR_W-1:0]   s00_axi_awaddr;
  logic [7:0]          s00_axi_awlen;
  logic [2:0]          s00_axi_awsize;
  logic [1:0]          s00_axi_awburst;
  logic                s00_axi_awvalid;
  logic                s00_axi_awready;
  logic [DATA_W-1:0]   s00_axi_wdata;
  logic [DATA_W/8-1:0] s00_axi_wstrb;
  logic                s00_axi_wlast;
  logic                s00_axi_wvalid;
  logic                s00_axi_wready;
  logic [ID_W-1:0]     s00_axi_bid;
  logic [1:0]          s00_axi_bresp;
  logic                s00_axi_bvalid;
  logic                s00_axi_bready;
  logic [ID_W-1:0]     s00_axi_arid;
  logic [ADDR_W-1:0]   s00_axi_araddr;
  logic [7:0]          s00_axi_arlen;
  logic [2:0]          s00_axi_arsize;
  logic [1:0]          s00_axi_arburst;
  logic                s00_axi_arvalid;
  logic                s00_axi_arready;
  logic [ID_W-1:0]     s00_axi_rid;
  logic [DATA_W-1:0]   s00_axi_rdata;
  logic [1:0]          s00_axi_rresp;
  logic                s00_axi_rlast;
  logic                s00_axi_rvalid;
  logic                s00_axi_rready;

  modport slave (
    input  s00_axi_awid, s00_axi_awaddr, s00_axi_awlen, s00_axi_awsize, s00_axi_awburst, s00_axi_awvalid,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wlast, s00_axi_wvalid, s00_axi_bready,
    input  s00_axi_arid, s00_axi_araddr, s00_axi_arlen, s00_axi_arsize, s00_axi_arburst, s00_axi_arvalid,
    input  s00_axi_rready,
    output s00_axi_awready, s00_axi_wready, s00_axi_bid, s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_arready, s00_axi_rid, s00_axi_rdata, s00_axi_rresp, s00_axi_rlast, s00_axi_rvalid
  );

  modport master (
    output s00_axi_awid, s00_axi_awaddr, s00_axi_awlen, s00_axi_awsize, s00_axi_awburst, s00_axi_awvalid,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wlast, s00_axi_wvalid, s00_axi_bready,
    output s00_axi_arid, s00_axi_araddr, s00_axi_arlen, s00_axi_arsize, s00_axi_arburst, s00_axi_arvalid,
    output s00_axi_rready,
    input  s00_axi_awready, s00_axi_wready, s00_axi_bid, s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_arready, s00_axi_rid, s00_axi_rdata, s00_axi_rresp, s00_axi_rlast, s00_axi_rvalid
  );
endinterface

// File: rtl/axi_burst_ram_slave.sv
// AXI4 slave over a byte-enabled RAM: FIXED/INCR/WRAP bursts, SLVERR on bad
// setup or out-of-range beats. Write and read FSMs run independently.
module axi_burst_ram_slave #(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 10,
  parameter int MEM_WORDS = 2**(ADDR_W-$clog2(DATA_W/8))
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_areset,
  axi_burst_ram_slave_if.slave axi
);
  localparam int STRB_W = DATA_W/8;
  localparam int OFF    = $clog2(STRB_W);
  // Extra headroom so INCR bursts can run past the last word and be flagged
  localparam int WW     = ADDR_W - OFF + 9;
  localparam int MI_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef logic [WW-1:0] word_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic word_t word_of(input logic [ADDR_W-1:0] a);
    return word_t'(a >> OFF);
  endfunction

  function automatic logic setup_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    return (size != 3'(OFF)) || (burst == 2'd3) ||
           (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // WRAP: len+1 is a power of two, so len is the mask of the wrapping bits
  function automatic word_t advance(input word_t w, input logic [7:0] len, input logic [1:0] burst);
    word_t m, inc;
    m   = word_t'(len);
    inc = w + word_t'(1);
    case (burst)
      2'd1:    return inc;
      2'd2:    return (w & ~m) | (inc & m);
      default: return w;
    endcase
  endfunction

  function automatic logic in_range(input word_t w);
    return w < word_t'(MEM_WORDS);
  endfunction

  // ---------------- write channel ----------------
  wstate_e         w_q, w_d;
  logic [ID_W-1:0] awid_q, awid_d;
  word_t           wword_q, wword_d;
  logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]      wburst_q, wburst_d;
  logic            werr_q, werr_d, wslv_q, wslv_d, mem_we;

  always_comb begin
    w_d = w_q; awid_d = awid_q; wword_d = wword_q; wlen_d = wlen_q;
    wburst_d = wburst_q; werr_d = werr_q; wslv_d = wslv_q; wcnt_d = wcnt_q;
    mem_we = 1'b0;
    unique case (w_q)
      W_IDLE: if (axi.s00_axi_awvalid) begin
        awid_d   = axi.s00_axi_awid;
        wword_d  = word_of(axi.s00_axi_awaddr);
        wlen_d   = axi.s00_axi_awlen;
        wburst_d = axi.s00_axi_awburst;
        werr_d   = setup_err(axi.s00_axi_awsize, axi.s00_axi_awburst, axi.s00_axi_awlen);
        wslv_d   = 1'b0;
        wcnt_d   = '0;
        w_d      = W_DATA;
      end
      W_DATA: if (axi.s00_axi_wvalid) begin
        mem_we = !werr_q && in_range(wword_q);
        if (!in_range(wword_q) || (axi.s00_axi_wlast != (wcnt_q == wlen_q))) wslv_d = 1'b1;
        if (wcnt_q == wlen_q) w_d = W_RESP;
        else begin
          wcnt_d  = wcnt_q + 8'd1;
          wword_d = advance(wword_q, wlen_q, wburst_q);
        end
      end
      W_RESP: if (axi.s00_axi_bready) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      w_q <= W_IDLE; awid_q <= '0; wword_q <= '0; wlen_q <= '0;
      wburst_q <= '0; werr_q <= 1'b0; wslv_q <= 1'b0; wcnt_q <= '0;
    end else begin
      w_q <= w_d; awid_q <= awid_d; wword_q <= wword_d; wlen_q <= wlen_d;
      wburst_q <= wburst_d; werr_q <= werr_d; wslv_q <= wslv_d; wcnt_q <= wcnt_d;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (mem_we)
      for (int b = 0; b < STRB_W; b++)
        if (axi.s00_axi_wstrb[b]) mem[wword_q[MI_W-1:0]][b*8 +: 8] <= axi.s00_axi_wdata[b*8 +: 8];
  end

  assign axi.s00_axi_awready = (w_q == W_IDLE) && !s00_axi_areset;
  assign axi.s00_axi_wready  = (w_q == W_DATA);
  assign axi.s00_axi_bvalid  = (w_q == W_RESP);
  assign axi.s00_axi_bresp   = ((w_q == W_RESP) && (werr_q || wslv_q)) ? 2'b10 : 2'b00;
  assign axi.s00_axi_bid     = awid_q;

  // ---------------- read channel ----------------
  rstate_e           r_q, r_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  word_t             rword_q, rword_d, r_addr;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]        rburst_q, rburst_d, rresp_q, rresp_d;
  logic              rerr_q, rerr_d, rlast_q, rlast_d, r_load, r_ok, e;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    r_d = r_q; arid_d = arid_q; rword_d = rword_q; rlen_d = rlen_q; rburst_d = rburst_q;
    rerr_d = rerr_q; rcnt_d = rcnt_q; rresp_d = rresp_q; rlast_d = rlast_q;
    r_load = 1'b0; r_addr = rword_q; r_ok = 1'b0; e = 1'b0;
    unique case (r_q)
      R_IDLE: if (axi.s00_axi_arvalid) begin
        e        = setup_err(axi.s00_axi_arsize, axi.s00_axi_arburst, axi.s00_axi_arlen);
        r_addr   = word_of(axi.s00_axi_araddr);
        r_ok     = !e && in_range(r_addr);
        r_load   = 1'b1;
        arid_d   = axi.s00_axi_arid;
        rword_d  = r_addr;
        rlen_d   = axi.s00_axi_arlen;
        rburst_d = axi.s00_axi_arburst;
        rerr_d   = e;
        rcnt_d   = '0;
        rlast_d  = (axi.s00_axi_arlen == 8'd0);
        rresp_d  = r_ok ? 2'b00 : 2'b10;
        r_d      = R_DATA;
      end
      R_DATA: if (axi.s00_axi_rready) begin
        if (rlast_q) begin
          rlast_d = 1'b0;
          rresp_d = 2'b00;
          r_d     = R_IDLE;
        end else begin
          // Fetch the next beat on the accepting edge: no bubble between beats
          r_addr  = advance(rword_q, rlen_q, rburst_q);
          r_ok    = !rerr_q && in_range(r_addr);
          r_load  = 1'b1;
          rword_d = r_addr;
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          rresp_d = r_ok ? 2'b00 : 2'b10;
        end
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_q <= R_IDLE; arid_q <= '0; rword_q <= '0; rlen_q <= '0; rburst_q <= '0;
      rerr_q <= 1'b0; rcnt_q <= '0; rresp_q <= '0; rlast_q <= 1'b0; rdata_q <= '0;
    end else begin
      r_q <= r_d; arid_q <= arid_d; rword_q <= rword_d; rlen_q <= rlen_d; rburst_q <= rburst_d;
      rerr_q <= rerr_d; rcnt_q <= rcnt_d; rresp_q <= rresp_d; rlast_q <= rlast_d;
      if (r_load) rdata_q <= r_ok ? mem[r_addr[MI_W-1:0]] : '0;
    end
  end

  assign axi.s00_axi_arready = (r_q == R_IDLE) && !s00_axi_areset;
  assign axi.s00_axi_rvalid  = (r_q == R_DATA);
  assign axi.s00_axi_rid     = arid_q;
  assign axi.s00_axi_rdata   = rdata_q;
  assign axi.s00_axi_rresp   = rresp_q;
  assign axi.s00_axi_rlast   = rlast_q;
endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed bench for axi_burst_ram_slave: a table of write/read bursts with
// hand-computed results, then stall and mid-burst reset sequences.
module tb_axi_burst_ram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_burst_ram_slave_if #(.ID_W(4), .DATA_W(512), .ADDR_W(10)) bus ();
  axi_burst_ram_slave #(.ID_W(4), .DATA_W(512), .ADDR_W(10)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .axi(bus.slave));

  typedef struct {
    bit              wr;
    logic [3:0]      id;
    logic [9:0]      addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [63:0]     strb;
    logic [3:0][511:0] dat;  // write data, or expected read data per beat
    logic [3:0][1:0] rs;     // rs[0] = expected bresp; per-beat rresp for reads
  } vec_t;

  vec_t q[$];
  localparam logic [511:0] Z    = '0;
  localparam logic [511:0] ONES = '1;
  localparam logic [511:0] LOW0 = {{480{1'b1}}, 32'h0};
  localparam logic [63:0]  AL   = '1;

  function automatic logic [511:0] dw(input int k);
    return {16{32'hA5A5_0000 + 32'(k)}};
  endfunction

  function automatic vec_t v(input bit wr, input logic [3:0] id, input logic [9:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [63:0] strb, input logic [3:0][511:0] dat, input logic [7:0] rs);
    vec_t r;
    r.wr = wr; r.id = id; r.addr = addr; r.len = len; r.size = size; r.burst = burst;
    r.strb = strb; r.dat = dat; r.rs = rs;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ctl"}, {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_bvalid, bus.s00_axi_arready,
                       bus.s00_axi_rvalid, bus.s00_axi_rlast, bus.s00_axi_bresp, bus.s00_axi_rresp,
                       bus.s00_axi_bid, bus.s00_axi_rid}, '0);
    chk({nm, " rdata"}, bus.s00_axi_rdata, '0);
  endtask

  task automatic do_write(input vec_t t, input string nm);
    int n;
    bus.s00_axi_awid = t.id; bus.s00_axi_awaddr = t.addr; bus.s00_axi_awlen = t.len;
    bus.s00_axi_awsize = t.size; bus.s00_axi_awburst = t.burst; bus.s00_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s00_axi_awready && n < 20) begin tick; n++; end
    chk({nm, " awready"}, bus.s00_axi_awready, 1);
    tick;
    bus.s00_axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(t.len); b++) begin
      bus.s00_axi_wdata = t.dat[b]; bus.s00_axi_wstrb = t.strb;
      bus.s00_axi_wlast = (b == int'(t.len)); bus.s00_axi_wvalid = 1'b1;
      n = 0;
      while (!bus.s00_axi_wready && n < 20) begin tick; n++; end
      chk({nm, " wready"}, bus.s00_axi_wready, 1);
      tick;
    end
    bus.s00_axi_wvalid = 1'b0; bus.s00_axi_wlast = 1'b0;
    chk({nm, " bvalid"}, bus.s00_axi_bvalid, 1);
    chk({nm, " bresp"}, bus.s00_axi_bresp, t.rs[0]);
    chk({nm, " bid"}, bus.s00_axi_bid, t.id);
    tick;
    chk({nm, " bvalid drop"}, bus.s00_axi_bvalid, 0);
  endtask

  task automatic do_read(input vec_t t, input string nm);
    int n;
    bus.s00_axi_rready = 1'b1;
    bus.s00_axi_arid = t.id; bus.s00_axi_araddr = t.addr; bus.s00_axi_arlen = t.len;
    bus.s00_axi_arsize = t.size; bus.s00_axi_arburst = t.burst; bus.s00_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s00_axi_arready && n < 20) begin tick; n++; end
    chk({nm, " arready"}, bus.s00_axi_arready, 1);
    tick;
    bus.s00_axi_arvalid = 1'b0;
    for (int b = 0; b <= int'(t.len); b++) begin
      chk($sformatf("%s rvalid b%0d", nm, b), bus.s00_axi_rvalid, 1);
      chk($sformatf("%s rdata b%0d", nm, b), bus.s00_axi_rdata, t.dat[b]);
      chk($sformatf("%s rresp b%0d", nm, b), bus.s00_axi_rresp, t.rs[b]);
      chk($sformatf("%s rlast b%0d", nm, b), bus.s00_axi_rlast, (b == int'(t.len)));
      if (b == 0) chk({nm, " rid"}, bus.s00_axi_rid, t.id);
      tick;
    end
    chk({nm, " rvalid drop"}, bus.s00_axi_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k, n;
    logic hold;
    logic [514:0] prev;

    q.push_back(v(1, 4'd5,  10'h040, 8'd3, 3'd6, 2'd1, AL, {dw(3), dw(2), dw(1), dw(0)}, 8'h00));
    q.push_back(v(0, 4'd3,  10'h040, 8'd3, 3'd6, 2'd1, AL, {dw(3), dw(2), dw(1), dw(0)}, 8'h00));
    q.push_back(v(1, 4'd1,  10'h0C0, 8'd3, 3'd6, 2'd2, AL, {dw(7), dw(6), dw(5), dw(4)}, 8'h00));
    q.push_back(v(0, 4'd2,  10'h000, 8'd3, 3'd6, 2'd1, AL, {dw(4), dw(7), dw(6), dw(5)}, 8'h00));
    q.push_back(v(1, 4'd4,  10'h140, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, ONES}, 8'h00));
    q.push_back(v(1, 4'd4,  10'h140, 8'd0, 3'd6, 2'd1, 64'hF, {Z, Z, Z, Z}, 8'h00));
    q.push_back(v(0, 4'd6,  10'h140, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, LOW0}, 8'h00));
    q.push_back(v(1, 4'd8,  10'h140, 8'd0, 3'd3, 2'd1, AL, {Z, Z, Z, dw(10)}, 8'h02));
    q.push_back(v(0, 4'd9,  10'h140, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, LOW0}, 8'h00));
    q.push_back(v(0, 4'd10, 10'h000, 8'd3, 3'd6, 2'd3, AL, {Z, Z, Z, Z}, 8'hAA));
    q.push_back(v(1, 4'd11, 10'h000, 8'd2, 3'd6, 2'd2, AL, {Z, dw(13), dw(12), dw(11)}, 8'h02));
    q.push_back(v(0, 4'd12, 10'h000, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, dw(5)}, 8'h00));
    q.push_back(v(1, 4'd12, 10'h3C0, 8'd1, 3'd6, 2'd1, AL, {Z, Z, dw(9), dw(8)}, 8'h02));
    q.push_back(v(1, 4'd13, 10'h380, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, dw(12)}, 8'h00));
    q.push_back(v(0, 4'd14, 10'h0C0, 8'd1, 3'd6, 2'd0, AL, {Z, Z, dw(4), dw(4)}, 8'h00));
    q.push_back(v(0, 4'd15, 10'h040, 8'd3, 3'd6, 2'd2, AL, {dw(5), dw(4), dw(7), dw(6)}, 8'h00));

    bus.s00_axi_awid = '0; bus.s00_axi_awaddr = '0; bus.s00_axi_awlen = '0; bus.s00_axi_awsize = '0;
    bus.s00_axi_awburst = '0; bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wdata = '0; bus.s00_axi_wstrb = '0;
    bus.s00_axi_wlast = 1'b0; bus.s00_axi_wvalid = 1'b0; bus.s00_axi_bready = 1'b1;
    bus.s00_axi_arid = '0; bus.s00_axi_araddr = '0; bus.s00_axi_arlen = '0; bus.s00_axi_arsize = '0;
    bus.s00_axi_arburst = '0; bus.s00_axi_arvalid = 1'b0; bus.s00_axi_rready = 1'b1;

    tick; tick;
    chk_zero("reset");
    rst = 1'b0;
    #1;
    chk("post-reset awready", bus.s00_axi_awready, 1);
    chk("post-reset arready", bus.s00_axi_arready, 1);
    tick;

    foreach (q[i]) begin
      if (q[i].wr) do_write(q[i], $sformatf("vec%0d wr", i));
      else         do_read(q[i], $sformatf("vec%0d rd", i));
    end

    // INCR read from word 14 runs off the end; rready alternates 0,1
    bus.s00_axi_arid = 4'd7; bus.s00_axi_araddr = 10'h380; bus.s00_axi_arlen = 8'd3;
    bus.s00_axi_arsize = 3'd6; bus.s00_axi_arburst = 2'd1; bus.s00_axi_arvalid = 1'b1;
    bus.s00_axi_rready = 1'b0;
    tick;
    bus.s00_axi_arvalid = 1'b0;
    k = 0; hold = 1'b0; prev = '0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      bus.s00_axi_rready = (c % 2 == 1);
      if (hold)
        chk($sformatf("stall stable c%0d", c),
            {bus.s00_axi_rlast, bus.s00_axi_rresp, bus.s00_axi_rdata}, prev);
      if (bus.s00_axi_rvalid && bus.s00_axi_rready) begin
        chk($sformatf("stall rdata b%0d", k), bus.s00_axi_rdata,
            (k == 0) ? dw(12) : (k == 1) ? dw(8) : Z);
        chk($sformatf("stall rresp b%0d", k), bus.s00_axi_rresp, (k < 2) ? 2'b00 : 2'b10);
        chk($sformatf("stall rlast b%0d", k), bus.s00_axi_rlast, (k == 3));
        k++;
      end
      hold = bus.s00_axi_rvalid && !bus.s00_axi_rready;
      prev = {bus.s00_axi_rlast, bus.s00_axi_rresp, bus.s00_axi_rdata};
      tick;
    end
    chk("stall beat count", 32'(k), 32'd4);
    chk("stall rvalid drop", bus.s00_axi_rvalid, 0);

    // Reset during the 2nd W beat with a stalled read burst also in flight
    bus.s00_axi_rready = 1'b0;
    bus.s00_axi_arid = 4'd6; bus.s00_axi_araddr = 10'h0C0; bus.s00_axi_arlen = 8'd3;
    bus.s00_axi_arburst = 2'd1; bus.s00_axi_arvalid = 1'b1;
    tick;
    bus.s00_axi_arvalid = 1'b0;
    chk("abort rvalid pending", bus.s00_axi_rvalid, 1);
    bus.s00_axi_awid = 4'd2; bus.s00_axi_awaddr = 10'h000; bus.s00_axi_awlen = 8'd3;
    bus.s00_axi_awsize = 3'd6; bus.s00_axi_awburst = 2'd1; bus.s00_axi_awvalid = 1'b1;
    tick;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata = dw(13); bus.s00_axi_wstrb = AL; bus.s00_axi_wvalid = 1'b1;
    tick;
    bus.s00_axi_wdata = dw(14);
    rst = 1'b1;
    #1;
    chk_zero("abort reset");
    bus.s00_axi_wvalid = 1'b0;
    tick; tick;
    rst = 1'b0;
    bus.s00_axi_rready = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.s00_axi_bvalid || bus.s00_axi_rvalid) n++;
      tick;
    end
    chk("abort no stale response", 32'(n), 32'd0);
    do_write(v(1, 4'd9, 10'h000, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, dw(15)}, 8'h00), "after abort wr");
    do_read(v(0, 4'd3, 10'h000, 8'd0, 3'd6, 2'd1, AL, {Z, Z, Z, dw(15)}, 8'h00), "after abort rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
